// File: rtl/mem_access.sv
// Pipeline MEM stage: issues data-memory requests for loads/stores, waits for
// the bus acknowledge (with timeout) and registers the MEM/WB outputs.
module mem_access #(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        memtoreg_i,
  input  logic        regwrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  write_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        memtoreg_o,
  output logic        regwrite_o,
  output logic [4:0]  write_addr_o,
  output logic [31:0] write_data_o,
  output logic [31:0] read_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dbg_state
);

  // Bus handshake: dmem_req is held high for the whole WAIT period and the
  // transfer completes on the first cycle where dmem_req and dmem_ack are both
  // high; address, data, enables and we stay stable while dmem_req is high.

  localparam int unsigned CW = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(DMEM_TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;
  logic [3:0]  lat_be;
  logic [4:0]  lat_waddr;
  logic        lat_we, lat_memtoreg, lat_regwrite, lat_flushed;

  logic        mem_op, access_ok, start, timed_out, ack_ok;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, shifted, load_val;

  logic        nx_memtoreg, nx_regwrite, nx_misalign, nx_bus_err;
  logic [4:0]  nx_waddr;
  logic [31:0] nx_wdata, nx_rdata;

  assign mem_op = valid_i & (memread_i | memwrite_i) & ~flush_i;

  always_comb begin
    access_ok = 1'b0;
    case (funct3_i[1:0])
      2'b00:   access_ok = 1'b1;
      2'b01:   access_ok = ~alu_result_i[0];
      2'b10:   access_ok = (alu_result_i[1:0] == 2'b00);
      default: access_ok = 1'b0;
    endcase
    if (funct3_i == 3'b110) access_ok = 1'b0;
  end

  assign start     = (state_q == S_IDLE) & mem_op & access_ok;
  assign timed_out = (state_q == S_WAIT) & (cnt_q == TIMEOUT_VAL);
  assign ack_ok    = (state_q == S_WAIT) & dmem_ack & ~timed_out;

  // Replicate narrow store data across all lanes; the byte enables pick the lane.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data_i;
    if (memwrite_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          st_be    = 4'b0001 << alu_result_i[1:0];
          st_wdata = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << alu_result_i[1:0];
          st_wdata = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign shifted = dmem_rdata >> {lat_addr[1:0], 3'b000};

  always_comb begin
    case (lat_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    nx_memtoreg = 1'b0;
    nx_regwrite = 1'b0;
    nx_waddr    = 5'd0;
    nx_wdata    = 32'd0;
    nx_rdata    = 32'd0;
    nx_misalign = 1'b0;
    nx_bus_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (access_ok) state_d = S_WAIT;
          else           nx_misalign = 1'b1;
        end else if (valid_i && !flush_i) begin
          nx_memtoreg = memtoreg_i;
          nx_regwrite = regwrite_i;
          nx_waddr    = write_addr_i;
          nx_wdata    = alu_result_i;
        end
      end
      S_WAIT: begin
        if (timed_out) begin
          state_d    = S_IDLE;
          nx_bus_err = 1'b1;
        end else if (dmem_ack) begin
          // A flush seen at any point in WAIT still completes the access but
          // must not update the register file.
          state_d     = S_IDLE;
          nx_memtoreg = lat_memtoreg;
          nx_regwrite = lat_regwrite & ~lat_flushed & ~flush_i;
          nx_waddr    = lat_waddr;
          nx_wdata    = lat_addr;
          nx_rdata    = lat_we ? 32'd0 : load_val;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset gates the combinational stall so it drops without waiting for a clock.
  assign stall_o    = ~rst & (start | ((state_q == S_WAIT) & ~ack_ok & ~timed_out));
  assign dmem_req   = (state_q == S_WAIT) & ~timed_out;
  assign dmem_we    = dmem_req & lat_we;
  assign dmem_addr  = dmem_req ? {lat_addr[31:2], 2'b00} : 32'd0;
  assign dmem_be    = dmem_req ? lat_be : 4'b0000;
  assign dmem_wdata = dmem_we ? lat_wdata : 32'd0;
  assign dbg_state  = (state_q == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_f3       <= 3'd0;
      lat_be       <= 4'd0;
      lat_waddr    <= 5'd0;
      lat_we       <= 1'b0;
      lat_memtoreg <= 1'b0;
      lat_regwrite <= 1'b0;
      lat_flushed  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        lat_addr     <= alu_result_i;
        lat_wdata    <= st_wdata;
        lat_f3       <= funct3_i;
        lat_be       <= memwrite_i ? st_be : 4'b1111;
        lat_waddr    <= write_addr_i;
        lat_we       <= memwrite_i;
        lat_memtoreg <= memtoreg_i;
        lat_regwrite <= regwrite_i;
        lat_flushed  <= 1'b0;
        cnt_q        <= '0;
      end else if (state_q == S_WAIT) begin
        if (flush_i) lat_flushed <= 1'b1;
        if (!dmem_ack && !timed_out) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memtoreg_o   <= 1'b0;
      regwrite_o   <= 1'b0;
      write_addr_o <= 5'd0;
      write_data_o <= 32'd0;
      read_data_o  <= 32'd0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      memtoreg_o   <= nx_memtoreg;
      regwrite_o   <= nx_regwrite;
      write_addr_o <= nx_waddr;
      write_data_o <= nx_wdata;
      read_data_o  <= nx_rdata;
      misalign_o   <= nx_misalign;
      bus_err_o    <= nx_bus_err;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized load/store/ALU
// traffic checked against an arithmetic reference model.
module tb_mem_access;
  localparam int TO = 4;

  logic        clk = 1'b0, rst;
  logic        valid_i, memread_i, memwrite_i, memtoreg_i, regwrite_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, store_data_i, dmem_rdata;
  logic [4:0]  write_addr_i;
  logic        dmem_ack;
  logic        stall_o, dmem_req, dmem_we, memtoreg_o, regwrite_o, misalign_o, bus_err_o, dbg_state;
  logic [31:0] dmem_addr, dmem_wdata, write_data_o, read_data_o;
  logic [3:0]  dmem_be;
  logic [4:0]  write_addr_o;

  int tests_run = 0, tests_failed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_access #(.DMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .memtoreg_i(memtoreg_i), .regwrite_i(regwrite_i), .funct3_i(funct3_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .write_addr_i(write_addr_i),
    .flush_i(flush_i), .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o),
    .write_addr_o(write_addr_o), .write_data_o(write_data_o), .read_data_o(read_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic model_legal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
    if (f3 % 4 == 0) return 1'b1;
    if (f3 % 4 == 1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3 % 4 == 0) return 4'(1 << (a % 4));
    if (f3 % 4 == 1) return 4'(3 << (a % 4));
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 % 4 == 0) return (sd % 256) * 32'h0101_0101;
    if (f3 % 4 == 1) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    valid_i = 0; memread_i = 0; memwrite_i = 0; memtoreg_i = 0; regwrite_i = 0; flush_i = 0;
    funct3_i = 0; alu_result_i = 0; store_data_i = 0; write_addr_i = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic present(input logic rd, input logic wr, input logic mtr, input logic rw,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wa);
    valid_i = 1; memread_i = rd; memwrite_i = wr; memtoreg_i = mtr; regwrite_i = rw;
    funct3_i = f3; alu_result_i = a; store_data_i = sd; write_addr_i = wa;
  endtask

  // Starts at posedge+1, returns at posedge+1 after the edge where the instruction leaves.
  task automatic run_mem(input logic rd, input logic wr, input logic mtr, input logic rw,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input logic [4:0] wa, input int ack_lat,
                         input logic flush_mid, output int stall_n, output int req_n,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic [3:0] o_be, output logic o_we, output logic done);
    stall_n = 0; req_n = 0; o_addr = 0; o_wdata = 0; o_be = 0; o_we = 0; done = 0;
    present(rd, wr, mtr, rw, f3, a, sd, wa);
    dmem_rdata = rdata;
    for (int cyc = 0; cyc < TO + 4; cyc++) begin
      flush_i  = flush_mid && (cyc == 1);
      dmem_ack = (cyc >= 1) && (cyc - 1 == ack_lat);
      @(negedge clk);
      if (stall_o) stall_n++;
      if (dmem_req) begin
        req_n++; o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
      end
      done = !stall_o;
      @(posedge clk); #1;
      if (done) break;
    end
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    tests_run++; if ({dmem_req, stall_o, regwrite_o, memtoreg_o, misalign_o, bus_err_o} !== 6'b0) begin tests_failed++; $display("FAIL reset_ctrl got=%b exp=000000", {dmem_req, stall_o, regwrite_o, memtoreg_o, misalign_o, bus_err_o}); end
    tests_run++; if ({write_data_o, read_data_o, write_addr_o, dmem_addr} !== 101'd0) begin tests_failed++; $display("FAIL reset_data got wd=%h rd=%h wa=%0d da=%h exp=0", write_data_o, read_data_o, write_addr_o, dmem_addr); end
    present(1, 0, 1, 1, 3'd2, 32'h40, 0, 5'd3);
    #1;
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_gated got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    tests_run++; if ({dbg_state, dmem_req, regwrite_o} !== 3'b0) begin tests_failed++; $display("FAIL reset_held got=%b exp=000", {dbg_state, dmem_req, regwrite_o}); end
    idle_inputs();
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    present(0, 0, 0, 1, 3'd0, 32'h0000_1234, 0, 5'd5);
    @(negedge clk);
    tests_run++; if ({stall_o, dmem_req} !== 2'b00) begin tests_failed++; $display("FAIL alu_no_stall got=%b exp=00", {stall_o, dmem_req}); end
    @(posedge clk); #1;
    idle_inputs();
    tests_run++; if ({regwrite_o, memtoreg_o, write_addr_o} !== {1'b1, 1'b0, 5'd5}) begin tests_failed++; $display("FAIL alu_ctrl got rw=%b mtr=%b wa=%0d exp rw=1 mtr=0 wa=5", regwrite_o, memtoreg_o, write_addr_o); end
    tests_run++; if ({write_data_o, read_data_o} !== {32'h0000_1234, 32'h0}) begin tests_failed++; $display("FAIL alu_data got wd=%h rd=%h exp wd=00001234 rd=0", write_data_o, read_data_o); end
    @(posedge clk); #1;
    tests_run++; if ({regwrite_o, write_addr_o} !== 6'd0) begin tests_failed++; $display("FAIL alu_bubble got rw=%b wa=%0d exp 0", regwrite_o, write_addr_o); end
  endtask

  task automatic test_load_byte();
    int s, r; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    run_mem(1, 0, 1, 1, 3'd0, 32'h103, 0, 32'h80FF_FFFF, 5'd7, 3, 0, s, r, oa, ow, ob, owe, d);
    tests_run++; if (d !== 1'b1) begin tests_failed++; $display("FAIL lb_done got=%b exp=1", d); end
    tests_run++; if (s != 4) begin tests_failed++; $display("FAIL lb_stall_cycles got=%0d exp=4", s); end
    tests_run++; if ({oa, ob, owe} !== {32'h100, 4'b1111, 1'b0}) begin tests_failed++; $display("FAIL lb_bus got a=%h be=%b we=%b exp a=100 be=1111 we=0", oa, ob, owe); end
    tests_run++; if (read_data_o !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL lb_data got=%h exp=ffffff80", read_data_o); end
    tests_run++; if ({memtoreg_o, regwrite_o, write_addr_o} !== {2'b11, 5'd7}) begin tests_failed++; $display("FAIL lb_ctrl got mtr=%b rw=%b wa=%0d exp 1 1 7", memtoreg_o, regwrite_o, write_addr_o); end
  endtask

  task automatic test_store_half();
    int s, r; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    run_mem(0, 1, 0, 0, 3'd1, 32'h202, 32'h0000_ABCD, 0, 5'd0, 1, 0, s, r, oa, ow, ob, owe, d);
    tests_run++; if ({oa, ob, ow, owe} !== {32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1}) begin tests_failed++; $display("FAIL sh_bus got a=%h be=%b wd=%h we=%b exp a=200 be=1100 wd=abcdabcd we=1", oa, ob, ow, owe); end
    tests_run++; if ({regwrite_o, r} !== {1'b0, 32'd2}) begin tests_failed++; $display("FAIL sh_commit got rw=%b req_cycles=%0d exp rw=0 req_cycles=2", regwrite_o, r); end
  endtask

  task automatic test_misalign();
    int s, r; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    run_mem(1, 0, 1, 1, 3'd2, 32'h101, 0, 0, 5'd4, 0, 0, s, r, oa, ow, ob, owe, d);
    tests_run++; if ({r, s} !== 64'd0) begin tests_failed++; $display("FAIL lw_mis_bus got req=%0d stall=%0d exp 0 0", r, s); end
    tests_run++; if ({misalign_o, regwrite_o} !== 2'b10) begin tests_failed++; $display("FAIL lw_mis_pulse got mis=%b rw=%b exp 1 0", misalign_o, regwrite_o); end
    @(posedge clk); #1;
    tests_run++; if (misalign_o !== 1'b0) begin tests_failed++; $display("FAIL lw_mis_one_cycle got=%b exp=0", misalign_o); end
  endtask

  task automatic test_timeout();
    int s, r; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    run_mem(1, 0, 1, 1, 3'd2, 32'h40, 0, 0, 5'd6, 99, 0, s, r, oa, ow, ob, owe, d);
    tests_run++; if (d !== 1'b1) begin tests_failed++; $display("FAIL to_done got=%b exp=1", d); end
    tests_run++; if ({r, s} !== {32'(TO), 32'(TO + 1)}) begin tests_failed++; $display("FAIL to_cycles got req=%0d stall=%0d exp req=%0d stall=%0d", r, s, TO, TO + 1); end
    tests_run++; if ({bus_err_o, regwrite_o} !== 2'b10) begin tests_failed++; $display("FAIL to_pulse got be=%b rw=%b exp 1 0", bus_err_o, regwrite_o); end
    @(posedge clk); #1;
    tests_run++; if ({bus_err_o, stall_o, dmem_req} !== 3'b0) begin tests_failed++; $display("FAIL to_after got=%b exp=000", {bus_err_o, stall_o, dmem_req}); end
  endtask

  task automatic test_reset_mid_wait();
    int s, r; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    present(1, 0, 1, 1, 3'd2, 32'h40, 0, 5'd9);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1;
    #1;
    tests_run++; if ({dmem_req, stall_o, dbg_state, regwrite_o} !== 4'b0) begin tests_failed++; $display("FAIL rstw_immediate got=%b exp=0000", {dmem_req, stall_o, dbg_state, regwrite_o}); end
    idle_inputs();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    tests_run++; if ({regwrite_o, write_addr_o, dmem_req} !== 7'd0) begin tests_failed++; $display("FAIL rstw_no_commit got rw=%b wa=%0d req=%b exp 0", regwrite_o, write_addr_o, dmem_req); end
    run_mem(1, 0, 1, 1, 3'd4, 32'h3, 0, 32'hAB00_0000, 5'd2, 0, 0, s, r, oa, ow, ob, owe, d);
    tests_run++; if ({read_data_o, r} !== {32'h0000_00AB, 32'd1}) begin tests_failed++; $display("FAIL rstw_lbu got rd=%h req=%0d exp rd=000000ab req=1", read_data_o, r); end
  endtask

  task automatic test_flush();
    int s, r; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    present(1, 0, 1, 1, 3'd2, 32'h80, 0, 5'd3);
    flush_i = 1;
    @(negedge clk);
    tests_run++; if ({stall_o, dmem_req} !== 2'b00) begin tests_failed++; $display("FAIL flush_idle_bus got=%b exp=00", {stall_o, dmem_req}); end
    @(posedge clk); #1;
    idle_inputs();
    tests_run++; if ({regwrite_o, memtoreg_o, write_addr_o, misalign_o, dbg_state} !== 9'd0) begin tests_failed++; $display("FAIL flush_idle_out got rw=%b mtr=%b wa=%0d mis=%b st=%b exp 0", regwrite_o, memtoreg_o, write_addr_o, misalign_o, dbg_state); end
    run_mem(1, 0, 1, 1, 3'd2, 32'h84, 0, 32'h1357_9BDF, 5'd8, 2, 1, s, r, oa, ow, ob, owe, d);
    tests_run++; if ({regwrite_o, read_data_o, r} !== {1'b0, 32'h1357_9BDF, 32'd3}) begin tests_failed++; $display("FAIL flush_wait_load got rw=%b rd=%h req=%0d exp rw=0 rd=13579bdf req=3", regwrite_o, read_data_o, r); end
    run_mem(0, 1, 0, 0, 3'd2, 32'h88, 32'hDEAD_BEEF, 0, 5'd0, 1, 1, s, r, oa, ow, ob, owe, d);
    tests_run++; if ({owe, ow, oa} !== {1'b1, 32'hDEAD_BEEF, 32'h88}) begin tests_failed++; $display("FAIL flush_wait_store got we=%b wd=%h a=%h exp we=1 wd=deadbeef a=88", owe, ow, oa); end
  endtask

  task automatic test_ack_ignored();
    present(0, 0, 0, 1, 3'd0, 32'hCAFE_0001, 0, 5'd11);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    tests_run++; if ({stall_o, dmem_req} !== 2'b00) begin tests_failed++; $display("FAIL ackidle_bus got=%b exp=00", {stall_o, dmem_req}); end
    @(posedge clk); #1;
    valid_i = 0;
    tests_run++; if ({regwrite_o, write_data_o, read_data_o} !== {1'b1, 32'hCAFE_0001, 32'h0}) begin tests_failed++; $display("FAIL ackidle_out got rw=%b wd=%h rd=%h exp rw=1 wd=cafe0001 rd=0", regwrite_o, write_data_o, read_data_o); end
    @(posedge clk); #1;
    idle_inputs();
    tests_run++; if ({regwrite_o, read_data_o, dbg_state} !== 34'd0) begin tests_failed++; $display("FAIL ackidle_bubble got rw=%b rd=%h st=%b exp 0", regwrite_o, read_data_o, dbg_state); end
  endtask

  task automatic test_back_to_back();
    int s, r; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    for (int i = 1; i <= 3; i++) begin
      present(0, 0, 0, 1, 3'd0, 32'(i * 32'h111), 0, 5'(i + 20));
      @(posedge clk); #1;
      tests_run++; if ({write_addr_o, write_data_o} !== {5'(i + 20), 32'(i * 32'h111)}) begin tests_failed++; $display("FAIL b2b_alu%0d got wa=%0d wd=%h exp wa=%0d wd=%h", i, write_addr_o, write_data_o, i + 20, i * 32'h111); end
    end
    run_mem(1, 0, 1, 1, 3'd5, 32'h12, 0, 32'h9876_5432, 5'd1, 0, 0, s, r, oa, ow, ob, owe, d);
    tests_run++; if ({read_data_o, s} !== {32'h0000_9876, 32'd1}) begin tests_failed++; $display("FAIL b2b_lhu got rd=%h stall=%0d exp rd=00009876 stall=1", read_data_o, s); end
  endtask

  task automatic test_random();
    int s, r, lat; logic [31:0] oa, ow; logic [3:0] ob; logic owe, d;
    logic rd, wr, rw, mtr, legal; logic [2:0] f3; logic [31:0] a, sd, rdata, ewd, erd; logic [4:0] wa;
    for (int n = 0; n < 80; n++) begin
      a = $urandom; sd = $urandom; rdata = $urandom; wa = 5'($urandom);
      rw = 1'($urandom); mtr = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        present(0, 0, mtr, rw, 3'($urandom), a, sd, wa);
        exp_q.push_back(a);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL rnd%0d_alu_stall got=%b exp=0", n, stall_o); end
        @(posedge clk); #1;
        idle_inputs();
        ewd = exp_q.pop_front();
        tests_run++; if ({regwrite_o, memtoreg_o, write_addr_o, write_data_o, read_data_o} !== {rw, mtr, wa, ewd, 32'h0}) begin tests_failed++; $display("FAIL rnd%0d_alu got rw=%b mtr=%b wa=%0d wd=%h rd=%h exp rw=%b mtr=%b wa=%0d wd=%h rd=0", n, regwrite_o, memtoreg_o, write_addr_o, write_data_o, read_data_o, rw, mtr, wa, ewd); end
        continue;
      end
      wr = 1'($urandom); rd = ~wr;
      case ($urandom_range(0, 9))
        0: f3 = 3'd3; 1: f3 = 3'd6; 2: f3 = 3'd0; 3: f3 = 3'd1; 4: f3 = 3'd1;
        default: f3 = 3'd2;
      endcase
      if (rd && $urandom_range(0, 2) == 0) f3 = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      lat = $urandom_range(0, TO);
      legal = model_legal(f3, a);
      run_mem(rd, wr, mtr, rw, f3, a, sd, rdata, wa, lat, 0, s, r, oa, ow, ob, owe, d);
      tests_run++; if (d !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d_done got=%b exp=1", n, d); end
      if (!legal) begin
        tests_run++; if ({r, misalign_o, regwrite_o, bus_err_o} !== {32'd0, 3'b100}) begin tests_failed++; $display("FAIL rnd%0d_illegal got req=%0d mis=%b rw=%b be=%b exp 0 1 0 0", n, r, misalign_o, regwrite_o, bus_err_o); end
      end else if (lat >= TO) begin
        tests_run++; if ({r, bus_err_o, regwrite_o, misalign_o} !== {32'(TO), 3'b100}) begin tests_failed++; $display("FAIL rnd%0d_timeout got req=%0d be=%b rw=%b mis=%b exp %0d 1 0 0", n, r, bus_err_o, regwrite_o, misalign_o, TO); end
      end else begin
        exp_q.push_back(a);
        exp_q.push_back(rd ? model_load(f3, a, rdata) : 32'h0);
        ewd = exp_q.pop_front(); erd = exp_q.pop_front();
        tests_run++; if ({s, r, oa, owe} !== {32'(lat + 1), 32'(lat + 1), a & 32'hFFFF_FFFC, wr}) begin tests_failed++; $display("FAIL rnd%0d_bus got stall=%0d req=%0d a=%h we=%b exp %0d %0d %h %b", n, s, r, oa, owe, lat + 1, lat + 1, a & 32'hFFFF_FFFC, wr); end
        if (wr) begin
          tests_run++; if ({ob, ow} !== {model_be(f3, a), model_wdata(f3, sd)}) begin tests_failed++; $display("FAIL rnd%0d_lanes got be=%b wd=%h exp be=%b wd=%h", n, ob, ow, model_be(f3, a), model_wdata(f3, sd)); end
        end else begin
          tests_run++; if (ob !== 4'b1111) begin tests_failed++; $display("FAIL rnd%0d_load_be got=%b exp=1111", n, ob); end
        end
        tests_run++; if ({regwrite_o, memtoreg_o, write_addr_o, write_data_o, read_data_o} !== {rw, mtr, wa, ewd, erd}) begin tests_failed++; $display("FAIL rnd%0d_commit got rw=%b mtr=%b wa=%0d wd=%h rd=%h exp rw=%b mtr=%b wa=%0d wd=%h rd=%h", n, regwrite_o, memtoreg_o, write_addr_o, write_data_o, read_data_o, rw, mtr, wa, ewd, erd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_flush();
    test_ack_ignored();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
